// File: rtl/nx_fifo_ram_ctrl_if.sv
// Producer/consumer stream plus external 1R1W RAM port bundle for nx_fifo_ram_ctrl.
// master = controller side, slave = environment (producer, consumer, RAM macro).
interface nx_fifo_ram_ctrl_if #(
   parameter int WIDTH = 83,
   parameter int AW    = 8
);
   logic             wr_vld;
   logic [WIDTH-1:0] wr_dat;
   logic             wr_rdy;
   logic             rd_vld;
   logic [WIDTH-1:0] rd_dat;
   logic             rd_rdy;
   logic             ram_web;
   logic [AW-1:0]    ram_wa;
   logic [WIDTH-1:0] ram_din;
   logic [WIDTH-1:0] ram_bwe;
   logic             ram_reb;
   logic [AW-1:0]    ram_ra;
   logic [WIDTH-1:0] ram_dout;
   logic [AW:0]      fill_cnt;

   modport master (
      input  wr_vld, wr_dat, rd_rdy, ram_dout,
      output wr_rdy, rd_vld, rd_dat, ram_web, ram_wa, ram_din, ram_bwe,
             ram_reb, ram_ra, fill_cnt
   );

   modport slave (
      output wr_vld, wr_dat, rd_rdy, ram_dout,
      input  wr_rdy, rd_vld, rd_dat, ram_web, ram_wa, ram_din, ram_bwe,
             ram_reb, ram_ra, fill_cnt
   );
endinterface

// File: rtl/nx_fifo_ram_ctrl.sv
// Valid/ready FIFO controller around an external 1R1W RAM with 2-cycle registered reads.
// Reads are credit-issued into a small skid buffer so the consumer may stall at any time.
module nx_fifo_ram_ctrl #(
   parameter int WIDTH      = 83,
   parameter int DEPTH      = 168,
   parameter int AW         = $clog2(DEPTH),
   parameter int RD_LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst,
   nx_fifo_ram_ctrl_if.master bus
);
   localparam int SKID = RD_LATENCY + 2;
   localparam int SW   = $clog2(SKID);
   localparam int CW   = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] FILL_MX = CW'(DEPTH + SKID);
   localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
   localparam logic [SW-1:0] LAST_S  = SW'(SKID - 1);
   localparam logic [SW:0]   SKID_C  = (SW+1)'(SKID);

   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       ram_used, ram_used_n;
   logic [CW-1:0]       avail_cnt, avail_cnt_n;
   logic [CW-1:0]       fill_q, fill_n;
   logic                wr_rdy, wr_acc, wr_acc_d1;
   logic                iss, push, pop, rd_vld;
   logic [RD_LATENCY:1] vld_pipe;
   logic [SW:0]         skid_cnt, skid_cnt_n, credit_use;
   logic [SW-1:0]       skid_hd, skid_tl;
   logic [WIDTH-1:0]    skid_mem [SKID];

   // ram_used counts every accepted entry not yet issued, including writes the RAM
   // has not committed yet; avail_cnt only counts committed (readable) entries.
   assign wr_rdy = ~rst & (ram_used != DEPTH_C);
   assign wr_acc = bus.wr_vld & wr_rdy;

   // Credits: reads in flight plus skid occupancy may never exceed the skid depth.
   always_comb begin
      credit_use = skid_cnt;
      for (int i = 1; i <= RD_LATENCY; i++) credit_use = credit_use + (SW+1)'(vld_pipe[i]);
   end

   assign iss    = (avail_cnt != '0) & (credit_use < SKID_C);
   assign push   = vld_pipe[RD_LATENCY];
   assign rd_vld = (skid_cnt != '0);
   assign pop    = rd_vld & bus.rd_rdy;

   always_comb begin
      ram_used_n  = ram_used + CW'(wr_acc) - CW'(iss);
      avail_cnt_n = avail_cnt + CW'(wr_acc_d1) - CW'(iss);
      skid_cnt_n  = skid_cnt + (SW+1)'(push) - (SW+1)'(pop);
      fill_n      = ram_used_n + CW'(skid_cnt_n) + CW'(iss);
      for (int i = 1; i < RD_LATENCY; i++) fill_n = fill_n + CW'(vld_pipe[i]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ram_used  <= '0;
         avail_cnt <= '0;
         wr_acc_d1 <= 1'b0;
         vld_pipe  <= '0;
         skid_cnt  <= '0;
         skid_hd   <= '0;
         skid_tl   <= '0;
         fill_q    <= '0;
      end else begin
         wr_acc_d1 <= wr_acc;
         ram_used  <= ram_used_n;
         avail_cnt <= avail_cnt_n;
         vld_pipe  <= {vld_pipe[RD_LATENCY-1:1], iss};
         skid_cnt  <= skid_cnt_n;
         fill_q    <= fill_n;
         if (wr_acc) wr_ptr  <= (wr_ptr == LAST_A) ? '0 : wr_ptr + AW'(1);
         if (iss)    rd_ptr  <= (rd_ptr == LAST_A) ? '0 : rd_ptr + AW'(1);
         if (push)   skid_tl <= (skid_tl == LAST_S) ? '0 : skid_tl + SW'(1);
         if (pop)    skid_hd <= (skid_hd == LAST_S) ? '0 : skid_hd + SW'(1);
      end
   end

   // Skid data needs no reset: slots are only read while counted valid.
   always_ff @(posedge clk) begin
      if (push) skid_mem[skid_tl] <= bus.ram_dout;
   end

   assign bus.wr_rdy   = wr_rdy;
   assign bus.ram_web  = ~wr_acc;
   assign bus.ram_wa   = wr_ptr;
   assign bus.ram_din  = bus.wr_dat;
   assign bus.ram_bwe  = '1;
   assign bus.ram_reb  = ~iss;
   assign bus.ram_ra   = rd_ptr;
   assign bus.rd_vld   = rd_vld;
   assign bus.rd_dat   = skid_mem[skid_hd];
   assign bus.fill_cnt = fill_q;

   a_skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && (skid_cnt == SKID_C)));
   a_fill_bound: assert property (@(posedge clk) disable iff (rst) fill_q <= FILL_MX);
endmodule

// File: tb/tb_nx_fifo_ram_ctrl.sv
// Bench for nx_fifo_ram_ctrl: RAM macro model, queue scoreboard monitor and scenario tasks.
module tb_nx_fifo_ram_ctrl;
   localparam int WIDTH = 83;
   localparam int DEPTH = 168;
   localparam int AW    = 8;
   localparam int SKID  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nx_fifo_ram_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
   nx_fifo_ram_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   // RAM macro: write flopped at one edge and committed at the next; read sampled at issue, 2-cycle latency.
   logic [WIDTH-1:0] mem [DEPTH];
   logic             wq_v = 1'b0;
   logic [AW-1:0]    wq_a;
   logic [WIDTH-1:0] wq_d, rs1, rs2;
   always @(posedge clk) begin
      if (wq_v) mem[wq_a] <= wq_d;
      wq_v <= !bus.ram_web;
      wq_a <= bus.ram_wa;
      wq_d <= bus.ram_din;
      if (!bus.ram_reb) rs1 <= mem[bus.ram_ra];
      rs2 <= rs1;
   end
   assign bus.ram_dout = rs2;

   int errors = 0;
   int checks = 0;
   logic mon_en = 1'b0;

   // Reference model: FIFO of accepted words plus running totals of writes, issues and pops.
   logic [WIDTH-1:0] q[$];
   int wr_cnt, wr_cnt_d1, iss_cnt, pop_cnt, stall_seen, outst;
   logic prev_stall, acc_m, pop_m;
   logic [WIDTH-1:0] prev_dat;

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         wr_cnt = 0; wr_cnt_d1 = 0; iss_cnt = 0; pop_cnt = 0; prev_stall = 1'b0;
      end else if (mon_en) begin
         acc_m = (bus.wr_vld === 1'b1) && (bus.wr_rdy === 1'b1);
         pop_m = (bus.rd_vld === 1'b1) && (bus.rd_rdy === 1'b1);
         outst = iss_cnt - pop_cnt;
         checks++;
         if (bus.fill_cnt !== (AW+1)'(q.size())) begin
            errors++; $display("FAIL mon_fill_cnt: got %0d want %0d at %0t", bus.fill_cnt, q.size(), $time);
         end
         checks++;
         if (q.size() == 0) begin
            if (bus.rd_vld !== 1'b0) begin
               errors++; $display("FAIL mon_rd_vld_empty: got %b want 0 at %0t", bus.rd_vld, $time);
            end
         end else if (bus.rd_vld === 1'b1 && bus.rd_dat !== q[0]) begin
            errors++; $display("FAIL mon_rd_dat: got %h want %h at %0t", bus.rd_dat, q[0], $time);
         end
         if (prev_stall) begin
            checks++;
            if (bus.rd_vld !== 1'b1 || bus.rd_dat !== prev_dat) begin
               errors++; $display("FAIL mon_stall_hold: got %b/%h want 1/%h at %0t", bus.rd_vld, bus.rd_dat, prev_dat, $time);
            end
         end
         if (q.size() < DEPTH) begin
            checks++;
            if (bus.wr_rdy !== 1'b1) begin
               errors++; $display("FAIL mon_wr_rdy: got %b want 1 (held %0d) at %0t", bus.wr_rdy, q.size(), $time);
            end
         end
         checks++;
         if (bus.ram_web !== !acc_m) begin
            errors++; $display("FAIL mon_ram_web: got %b want %b at %0t", bus.ram_web, !acc_m, $time);
         end
         if (acc_m) begin
            checks++;
            if (bus.ram_wa !== AW'(wr_cnt % DEPTH) || bus.ram_din !== bus.wr_dat) begin
               errors++; $display("FAIL mon_wr_port: got wa %0d want %0d at %0t", bus.ram_wa, wr_cnt % DEPTH, $time);
            end
         end
         checks++;
         if (outst > SKID) begin
            errors++; $display("FAIL mon_credit: got %0d outstanding want <= %0d at %0t", outst, SKID, $time);
         end
         if (bus.ram_reb === 1'b0) begin
            checks++;
            if (bus.ram_ra !== AW'(iss_cnt % DEPTH) || iss_cnt >= wr_cnt_d1 || outst >= SKID) begin
               errors++; $display("FAIL mon_rd_issue: got ra %0d want %0d (iss %0d readable %0d outst %0d) at %0t",
                                  bus.ram_ra, iss_cnt % DEPTH, iss_cnt, wr_cnt_d1, outst, $time);
            end
         end
         prev_stall = (bus.rd_vld === 1'b1) && (bus.rd_rdy === 1'b0);
         prev_dat   = bus.rd_dat;
         if (prev_stall) stall_seen++;
         wr_cnt_d1 = wr_cnt;
         if (acc_m) begin q.push_back(bus.wr_dat); wr_cnt++; end
         if (pop_m) begin
            if (q.size() != 0) void'(q.pop_front());
            pop_cnt++;
         end
         if (bus.ram_reb === 1'b0) iss_cnt++;
      end
   end

   function automatic logic [WIDTH-1:0] rand_dat();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[WIDTH-1:0];
   endfunction

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.wr_rdy !== 1'b0) begin errors++; $display("FAIL reset_wr_rdy: got %b want 0", bus.wr_rdy); end
      checks++;
      if (bus.rd_vld !== 1'b0 || bus.fill_cnt !== 0) begin
         errors++; $display("FAIL reset_out: got rd_vld %b fill %0d want 0 0", bus.rd_vld, bus.fill_cnt);
      end
      checks++;
      if (bus.ram_web !== 1'b1 || bus.ram_reb !== 1'b1) begin
         errors++; $display("FAIL reset_ram_en: got web %b reb %b want 1 1", bus.ram_web, bus.ram_reb);
      end
      @(posedge clk); #1;
      rst = 1'b0; bus.wr_vld = 1'b0; mon_en = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.wr_rdy !== 1'b1 || bus.ram_bwe !== {WIDTH{1'b1}}) begin
         errors++; $display("FAIL post_reset: got wr_rdy %b bwe %h want 1 all-ones", bus.wr_rdy, bus.ram_bwe);
      end
   endtask

   task automatic test_single();
      logic [WIDTH-1:0] d;
      d = WIDTH'(32'h1234);
      for (int c = 0; c <= 5; c++) begin
         @(posedge clk); #1;
         bus.rd_rdy = 1'b0; bus.wr_vld = (c == 0); bus.wr_dat = d;
         @(negedge clk);
         checks++;
         case (c)
            0: if (bus.ram_web !== 1'b0 || bus.ram_wa !== 0) begin
                  errors++; $display("FAIL single_write: got web %b wa %0d want 0 0", bus.ram_web, bus.ram_wa);
               end
            2: if (bus.ram_reb !== 1'b0 || bus.ram_ra !== 0) begin
                  errors++; $display("FAIL single_issue: got reb %b ra %0d want 0 0", bus.ram_reb, bus.ram_ra);
               end
            5: if (bus.rd_vld !== 1'b1 || bus.rd_dat !== d) begin
                  errors++; $display("FAIL single_out: got %b/%h want 1/%h", bus.rd_vld, bus.rd_dat, d);
               end
            default: if (bus.rd_vld !== 1'b0 || bus.ram_reb !== 1'b1) begin
                  errors++; $display("FAIL single_idle_c%0d: got rd_vld %b reb %b want 0 1", c, bus.rd_vld, bus.ram_reb);
               end
         endcase
      end
      @(posedge clk); #1; bus.rd_rdy = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (bus.rd_vld !== 1'b0 || bus.fill_cnt !== 0) begin
         errors++; $display("FAIL single_drain: got rd_vld %b fill %0d want 0 0", bus.rd_vld, bus.fill_cnt);
      end
   endtask

   task automatic test_fill();
      int acc, cyc, pops0;
      bit a;
      acc = 0; cyc = 0;
      @(posedge clk); #1;
      bus.rd_rdy = 1'b0; bus.wr_vld = 1'b1; bus.wr_dat = rand_dat();
      while (acc < DEPTH + SKID && cyc < 500) begin
         @(negedge clk); cyc++;
         a = (bus.wr_rdy === 1'b1);
         if (a) acc++;
         @(posedge clk); #1;
         if (a) bus.wr_dat = rand_dat();
      end
      checks++;
      if (acc != DEPTH + SKID) begin errors++; $display("FAIL fill_accept: got %0d want %0d", acc, DEPTH + SKID); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (bus.wr_rdy !== 1'b0 || bus.ram_web !== 1'b1 || bus.fill_cnt !== DEPTH + SKID || bus.rd_vld !== 1'b1) begin
            errors++; $display("FAIL fill_full: got wr_rdy %b web %b fill %0d rd_vld %b want 0 1 %0d 1",
                               bus.wr_rdy, bus.ram_web, bus.fill_cnt, bus.rd_vld, DEPTH + SKID);
         end
         @(posedge clk); #1;
      end
      bus.wr_vld = 1'b0; bus.rd_rdy = 1'b1;
      pops0 = pop_cnt;
      for (cyc = 0; cyc < 600 && pop_cnt - pops0 < DEPTH + SKID; cyc++) @(posedge clk);
      checks++;
      if (pop_cnt - pops0 != DEPTH + SKID) begin
         errors++; $display("FAIL fill_drain_count: got %0d want %0d", pop_cnt - pops0, DEPTH + SKID);
      end
      @(negedge clk);
      checks++;
      if (bus.fill_cnt !== 0 || bus.rd_vld !== 1'b0) begin
         errors++; $display("FAIL fill_empty: got fill %0d rd_vld %b want 0 0", bus.fill_cnt, bus.rd_vld);
      end
   endtask

   task automatic test_stream();
      int acc, gaps, wraps, pops0, cyc;
      bit a;
      acc = 0; gaps = 0; wraps = 0;
      @(posedge clk); #1;
      bus.rd_rdy = 1'b1; bus.wr_vld = 1'b1; bus.wr_dat = rand_dat();
      pops0 = pop_cnt;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         a = (bus.wr_rdy === 1'b1);
         if (a) acc++;
         if (c >= 8 && bus.rd_vld !== 1'b1) gaps++;
         if (a && bus.ram_wa === AW'(DEPTH - 1)) wraps++;
         @(posedge clk); #1;
         if (a) bus.wr_dat = rand_dat();
      end
      bus.wr_vld = 1'b0;
      checks++;
      if (acc != 1000) begin errors++; $display("FAIL stream_accept: got %0d want 1000", acc); end
      checks++;
      if (gaps != 0) begin errors++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
      checks++;
      if (wraps != 5) begin errors++; $display("FAIL stream_wraps: got %0d want 5", wraps); end
      for (cyc = 0; cyc < 100 && pop_cnt - pops0 < 1000; cyc++) @(posedge clk);
      checks++;
      if (pop_cnt - pops0 != 1000) begin errors++; $display("FAIL stream_drain: got %0d want 1000", pop_cnt - pops0); end
   endtask

   task automatic test_random_stall();
      int acc, pops0, stall0, cyc;
      bit last_acc;
      acc = 0; last_acc = 1'b0;
      @(posedge clk); #1;
      bus.wr_vld = 1'b0;
      pops0 = pop_cnt; stall0 = stall_seen;
      for (int c = 0; c < 1500; c++) begin
         if (c != 0) begin @(posedge clk); #1; end
         if (!bus.wr_vld || last_acc) begin
            bus.wr_vld = ($urandom_range(0, 9) < 7);
            bus.wr_dat = rand_dat();
         end
         bus.rd_rdy = ($urandom_range(0, 9) < 3);
         @(negedge clk);
         last_acc = (bus.wr_vld === 1'b1) && (bus.wr_rdy === 1'b1);
         if (last_acc) acc++;
      end
      @(posedge clk); #1;
      bus.wr_vld = 1'b0; bus.rd_rdy = 1'b1;
      for (cyc = 0; cyc < 800 && pop_cnt - pops0 < acc; cyc++) @(posedge clk);
      checks++;
      if (pop_cnt - pops0 != acc) begin errors++; $display("FAIL random_drain: got %0d want %0d", pop_cnt - pops0, acc); end
      checks++;
      if (stall_seen - stall0 == 0) begin errors++; $display("FAIL random_stalls: got 0 want >0"); end
      @(negedge clk);
      checks++;
      if (bus.fill_cnt !== 0) begin errors++; $display("FAIL random_empty: got %0d want 0", bus.fill_cnt); end
   endtask

   task automatic test_reset_mid();
      logic [1:0] reb_hist;
      int lat;
      reb_hist = 2'b11;
      @(posedge clk); #1;
      bus.rd_rdy = 1'b1; bus.wr_vld = 1'b1; bus.wr_dat = rand_dat();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         reb_hist = {reb_hist[0], bus.ram_reb};
         @(posedge clk); #1;
         bus.wr_dat = rand_dat();
      end
      checks++;
      if (reb_hist !== 2'b00) begin errors++; $display("FAIL rstmid_inflight: got reb history %b want 00", reb_hist); end
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (bus.rd_vld !== 1'b0 || bus.fill_cnt !== 0 || bus.ram_web !== 1'b1 || bus.ram_reb !== 1'b1 || bus.wr_rdy !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs: got rd_vld %b fill %0d web %b reb %b wr_rdy %b want 0 0 1 1 0",
                               bus.rd_vld, bus.fill_cnt, bus.ram_web, bus.ram_reb, bus.wr_rdy);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0; bus.wr_vld = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (bus.rd_vld !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got rd_vld %b want 0", bus.rd_vld); end
         @(posedge clk); #1;
      end
      bus.wr_vld = 1'b1; bus.wr_dat = WIDTH'(32'hABC);
      lat = -1;
      for (int c = 0; c < 12 && lat < 0; c++) begin
         @(negedge clk);
         if (bus.rd_vld === 1'b1) begin
            lat = c;
            checks++;
            if (bus.rd_dat !== WIDTH'(32'hABC)) begin
               errors++; $display("FAIL rstmid_first: got %h want abc", bus.rd_dat);
            end
         end
         @(posedge clk); #1;
         bus.wr_vld = 1'b0;
      end
      checks++;
      if (lat != 5) begin errors++; $display("FAIL rstmid_latency: got %0d want 5", lat); end
   endtask

   initial begin
      bus.wr_vld = 1'b1; bus.wr_dat = '0; bus.rd_rdy = 1'b1;
      stall_seen = 0;
      test_reset();
      test_single();
      test_fill();
      test_stream();
      test_random_stall();
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: got timeout want completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end
endmodule
